// File: rtl/motor_out_pio_wdt_if.sv
// Avalon-MM slave bus bundle for the motor output PIO.
interface motor_out_pio_wdt_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/motor_out_pio_wdt.sv
// Motor/actuator output PIO with atomic set/clear and a refresh watchdog.
// Optional build macro MOTOR_PIO_STICKY_TRIP_EN: a trip stays latched until
// a TIMEOUT write (or reset); plain output writes no longer release it.
module motor_out_pio_wdt #(
    parameter int unsigned WIDTH           = 4,
    parameter logic [31:0] RESET_VALUE     = 32'd0,
    parameter logic [31:0] SAFE_VALUE      = 32'd0,
    parameter logic [31:0] TIMEOUT_DEFAULT = 32'd50000000
) (
    input  logic                  clk,
    input  logic                  reset,
    motor_out_pio_wdt_if.slave    bus,
    output logic [WIDTH-1:0]      out_port,
    output logic                  tripped
);

    localparam logic [1:0] A_DATA    = 2'd0;
    localparam logic [1:0] A_TIMEOUT = 2'd1;
    localparam logic [1:0] A_OUTSET  = 2'd2;
    localparam logic [1:0] A_OUTCLR  = 2'd3;

    typedef enum logic [1:0] {
        ST_DISARMED = 2'd0,
        ST_RUNNING  = 2'd1,
        ST_TRIPPED  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] data_reg;
    logic [31:0]      timeout_reg;
    logic [31:0]      cnt;

    logic             wr_c;
    logic             tmo_wr_c;
    logic             kick_c;
    logic [WIDTH-1:0] wdata_c;
    logic [31:0]      rd_mux_c;

    // Bus strobe decode; every non-TIMEOUT write refreshes the watchdog.
    assign wr_c     = bus.chipselect & ~bus.write_n;
    assign tmo_wr_c = wr_c && (bus.address == A_TIMEOUT);
    assign kick_c   = wr_c && (bus.address != A_TIMEOUT);
    assign wdata_c  = bus.writedata[WIDTH-1:0];

    // Outputs decoded straight from registers: safe value overrides while tripped.
    assign out_port = (state == ST_TRIPPED) ? SAFE_VALUE[WIDTH-1:0] : data_reg;
    assign tripped  = (state == ST_TRIPPED);

    // Read mux; OUTSET/OUTCLR addresses read back status and live count.
    always_comb begin
        rd_mux_c = '0;
        case (bus.address)
            A_DATA:    rd_mux_c = 32'(data_reg);
            A_TIMEOUT: rd_mux_c = timeout_reg;
            A_OUTSET:  rd_mux_c = {30'd0, (state != ST_DISARMED), (state == ST_TRIPPED)};
            default:   rd_mux_c = cnt;
        endcase
    end

    // Register file, watchdog countdown and state machine.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_reg     <= RESET_VALUE[WIDTH-1:0];
            timeout_reg  <= TIMEOUT_DEFAULT;
            cnt          <= TIMEOUT_DEFAULT;
            state        <= (TIMEOUT_DEFAULT != 32'd0) ? ST_RUNNING : ST_DISARMED;
            bus.readdata <= '0;
        end else begin
            bus.readdata <= rd_mux_c;

            if (wr_c) begin
                case (bus.address)
                    A_DATA:   data_reg <= wdata_c;
                    A_OUTSET: data_reg <= data_reg | wdata_c;
                    A_OUTCLR: data_reg <= data_reg & ~wdata_c;
                    default:  ;
                endcase
            end

            if (tmo_wr_c) begin
                // Re-arming takes priority over expiry and always clears a trip.
                timeout_reg <= bus.writedata;
                cnt         <= bus.writedata;
                state       <= (bus.writedata == 32'd0) ? ST_DISARMED : ST_RUNNING;
            end else begin
                case (state)
                    ST_RUNNING: begin
                        if (kick_c) begin
                            cnt <= timeout_reg;
                        end else if (cnt <= 32'd1) begin
                            cnt   <= 32'd0;
                            state <= ST_TRIPPED;
                        end else begin
                            cnt <= cnt - 32'd1;
                        end
                    end
                    ST_TRIPPED: begin
                        if (kick_c) begin
                            cnt <= timeout_reg;
`ifdef MOTOR_PIO_STICKY_TRIP_EN
                            state <= ST_TRIPPED;
`else
                            state <= ST_RUNNING;
`endif
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_motor_out_pio_wdt.sv
// Randomized self-checking bench for motor_out_pio_wdt against a deadline-based model.
module tb_motor_out_pio_wdt;

    localparam int unsigned WIDTH = 4;
    localparam logic [31:0] TD    = 32'd50000000;
    localparam logic [31:0] SAFE  = 32'd0;
    localparam logic [31:0] RSTV  = 32'd0;

    logic             clk;
    logic             reset;
    logic [WIDTH-1:0] out_port;
    logic             tripped;

    motor_out_pio_wdt_if bus_if ();

    motor_out_pio_wdt #(
        .WIDTH           (WIDTH),
        .RESET_VALUE     (RSTV),
        .SAFE_VALUE      (SAFE),
        .TIMEOUT_DEFAULT (TD)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus_if.slave),
        .out_port (out_port),
        .tripped  (tripped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: the watchdog is a deadline `timeout` edges after the last reload edge.
    longint      cyc;
    longint      m_ref;
    logic [31:0] m_data;
    logic [31:0] m_timeout;
    bit          m_armed;
    bit          m_latched;
    logic [31:0] m_hold;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%08h expected 0x%08h", tag, cyc, got, exp);
        end
    endtask

    function automatic bit m_tripped();
        longint el;
        el = cyc - m_ref;
        return m_armed && (m_latched || (el >= longint'(m_timeout)));
    endfunction

    function automatic logic [31:0] m_cnt();
        longint el;
        el = cyc - m_ref;
        if (!m_armed)                      return 32'd0;
        if (m_latched)                     return m_hold;
        if (el >= longint'(m_timeout))     return 32'd0;
        return 32'(longint'(m_timeout) - el);
    endfunction

    function automatic logic [31:0] m_out();
        return m_tripped() ? (SAFE & 32'hF) : m_data;
    endfunction

    function automatic logic [31:0] m_read(input logic [1:0] a);
        case (a)
            2'd0:    return m_data;
            2'd1:    return m_timeout;
            2'd2:    return {30'd0, m_armed, m_tripped()};
            default: return m_cnt();
        endcase
    endfunction

    task automatic model_reset();
        m_data    = RSTV & 32'hF;
        m_timeout = TD;
        m_armed   = (TD != 32'd0);
        m_latched = 1'b0;
        m_hold    = 32'd0;
        m_ref     = cyc;
    endtask

    // One bus cycle: drive, clock, update model, then compare all outputs.
    task automatic step(input bit rst, input logic [1:0] a, input bit cs, input bit wn,
                        input logic [31:0] wd);
        logic [31:0] exp_rd;
        bit          was_trip;
        reset               = rst;
        bus_if.address      = a;
        bus_if.chipselect   = cs;
        bus_if.write_n      = wn;
        bus_if.writedata    = wd;
        exp_rd   = rst ? 32'd0 : m_read(a);
        was_trip = m_tripped();
        @(posedge clk);
        cyc++;
        if (rst) begin
            model_reset();
        end else if (cs && !wn) begin
            if (a == 2'd1) begin
                m_timeout = wd;
                m_armed   = (wd != 32'd0);
                m_latched = 1'b0;
                m_ref     = cyc;
            end else begin
                case (a)
                    2'd0:    m_data = wd & 32'hF;
                    2'd2:    m_data = m_data | (wd & 32'hF);
                    default: m_data = m_data & ~wd & 32'hF;
                endcase
                if (m_armed) begin
`ifdef MOTOR_PIO_STICKY_TRIP_EN
                    if (was_trip) begin
                        m_latched = 1'b1;
                        m_hold    = m_timeout;
                    end else begin
                        m_ref = cyc;
                    end
`else
                    m_ref = cyc;
`endif
                end
            end
        end
        #1;
        check("readdata", bus_if.readdata, exp_rd);
        check("out_port", 32'(out_port), m_out());
        check("tripped", 32'(tripped), 32'(m_tripped()));
    endtask

    task automatic idle(input logic [1:0] a);
        step(1'b0, a, 1'b0, 1'b1, 32'd0);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] wd);
        step(1'b0, a, 1'b1, 1'b0, wd);
    endtask

    initial begin
        cyc = 0;
        model_reset();
        reset = 1'b1;
        bus_if.address = 2'd0; bus_if.chipselect = 1'b0;
        bus_if.write_n = 1'b1; bus_if.writedata = 32'd0;

        // Reset values and default timeout readback
        step(1'b1, 2'd0, 1'b0, 1'b1, 32'd0);
        step(1'b1, 2'd0, 1'b0, 1'b1, 32'd0);
        check("rst_out", 32'(out_port), 32'd0);
        idle(2'd1);
        check("rd_timeout_dflt", bus_if.readdata, 32'h02FAF080);
        idle(2'd2);
        check("rd_status_dflt", bus_if.readdata, 32'h2);

        // Data register with atomic set/clear; upper writedata bits ignored
        wr(2'd0, 32'hF5);  check("data_wr", 32'(out_port), 32'h5);
        wr(2'd2, 32'h8);   check("outset", 32'(out_port), 32'hD);
        wr(2'd3, 32'h1);   check("outclr", 32'(out_port), 32'hC);
        idle(2'd0);        check("rd_data", bus_if.readdata, 32'hC);

        // Trip exactly timeout edges after the TIMEOUT write
        wr(2'd1, 32'd10);
        for (int i = 0; i < 9; i++) idle(2'd0);
        check("pre_trip", 32'(tripped), 32'd0);
        idle(2'd0);
        check("trip_edge", 32'(tripped), 32'd1);
        check("trip_safe", 32'(out_port), SAFE & 32'hF);
        idle(2'd3);        check("rd_cnt_tripped", bus_if.readdata, 32'd0);
        idle(2'd2);        check("rd_status_trip", bus_if.readdata, 32'h3);

        // Kick coinciding with cnt==1 wins
        wr(2'd1, 32'd10);
        for (int i = 0; i < 9; i++) idle(2'd0);
        wr(2'd0, 32'h6);
        idle(2'd3);
        check("kick_reload", bus_if.readdata, 32'd10);
        check("kick_no_trip", 32'(tripped), 32'd0);

        // Kick while tripped
        for (int i = 0; i < 12; i++) idle(2'd0);
        wr(2'd0, 32'h3);
`ifdef MOTOR_PIO_STICKY_TRIP_EN
        check("sticky_trip", 32'(tripped), 32'd1);
        idle(2'd0);
        check("sticky_rd_data", bus_if.readdata, 32'h3);
        wr(2'd1, 32'd100);
        check("sticky_clear", 32'(tripped), 32'd0);
        check("sticky_out", 32'(out_port), 32'h3);
        wr(2'd1, 32'd10);
        for (int i = 0; i < 12; i++) idle(2'd0);
`else
        check("kick_untrip", 32'(tripped), 32'd0);
        check("kick_untrip_out", 32'(out_port), 32'h3);
        for (int i = 0; i < 12; i++) idle(2'd0);
`endif

        // Disarm while tripped; counter frozen
        wr(2'd1, 32'd0);
        check("disarm_out", 32'(out_port), 32'h3);
        for (int i = 0; i < 1000; i++) idle(2'd3);
        idle(2'd2);
        check("disarm_status", bus_if.readdata, 32'h0);

        // Reset in mid-countdown
        wr(2'd1, 32'd20);
        for (int i = 0; i < 7; i++) idle(2'd0);
        step(1'b1, 2'd3, 1'b1, 1'b0, 32'hF);
        check("midrst_out", 32'(out_port), 32'd0);
        idle(2'd1);
        check("midrst_timeout", bus_if.readdata, TD);

        // Randomized traffic
        for (int n = 0; n < 4000; n++) begin
            int unsigned r;
            r = $urandom_range(0, 999);
            if (r < 780) begin
                step(1'b0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b1, $urandom);
            end else if (r < 800) begin
                step(1'b0, 2'($urandom_range(0, 3)), 1'b0, 1'b0, $urandom);
            end else if (r < 930) begin
                logic [1:0] a;
                a = 2'($urandom_range(0, 2));
                if (a == 2'd1) a = 2'd3;
                wr(a, ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom);
            end else if (r < 995) begin
                wr(2'd1, 32'($urandom_range(0, 30)));
            end else begin
                step(1'b1, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0, $urandom);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/motor_out_pio_wdt.md
Name: motor_out_pio_wdt

Overview:
- Avalon-MM slave output port that drives the robot car's motor/actuator control lines from the Nios II processor.
- It is the write-direction counterpart to the sensor input PIOs on the same Qsys fabric.
- It adds atomic bit set/clear registers and a watchdog. If software stops refreshing the port for a programmed number of clocks, the outputs are forced to a safe value (motors off).

Parameters:
- WIDTH, 4: number of output bits driven on out_port (1..32).
- RESET_VALUE, 0: value of the data register after reset.
- SAFE_VALUE, 0: value driven on out_port while tripped.
- TIMEOUT_DEFAULT, 50000000: watchdog reload after reset, in clk cycles (1 s at 50 MHz). 0 means disarmed.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- address  in  2  register select.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  registered read data.
- out_port  out  WIDTH  actuator outputs.
- tripped  out  1  high while the watchdog has forced SAFE_VALUE.

Behaviour:
- One clock and one synchronous active-high reset; all state changes on the rising clk edge.
- wr = chipselect & ~write_n. No wait states; writes take effect at the edge where wr is sampled.
- Register map:
  - addr0 DATA, R/W: data_reg <= writedata[WIDTH-1:0]. Counts as a kick.
  - addr1 TIMEOUT, R/W: timeout_reg <= writedata; cnt <= writedata. State becomes DISARMED if writedata==0, else RUNNING. Always clears a trip.
  - addr2 OUTSET, W: data_reg <= data_reg | writedata[WIDTH-1:0]. Counts as a kick. Read returns STATUS: bit0 tripped, bit1 armed (state != DISARMED), others 0.
  - addr3 OUTCLR, W: data_reg <= data_reg & ~writedata[WIDTH-1:0]. Counts as a kick. Read returns cnt.
- Kick: cnt <= timeout_reg. If state is TRIPPED, go to RUNNING (see Optional Feature). In DISARMED a kick only updates data_reg.
- State machine DISARMED / RUNNING / TRIPPED:
  - RUNNING: with no kick, cnt decrements by 1 per cycle. If cnt==1 and no kick, the next state is TRIPPED with cnt=0. A trip therefore occurs exactly timeout_reg cycles after the last kick edge.
  - TRIPPED: cnt holds at 0. data_reg remains writable.
  - DISARMED: cnt holds.
- out_port = (state==TRIPPED) ? SAFE_VALUE[WIDTH-1:0] : data_reg. Decoded directly from registers, so it changes at the same edge that updates data_reg or state (1-cycle latency from wr).
- tripped = (state==TRIPPED).
- Read path:
  - readdata <= mux(address) every cycle, independent of chipselect. Read latency is 1 cycle.
  - Unused upper bits are 0. Reads have no side effects.
- Simultaneous events:
  - A kick in the same cycle as cnt==1 wins: reload, no trip.
  - A TIMEOUT write in the same cycle as expiry wins.
  - Writes to addr2/addr3 with writedata==0 are still kicks.
- Width rule: writedata bits above WIDTH-1 are ignored. The cnt and timeout_reg registers are 32-bit unsigned.
- Reset values:
  - data_reg=RESET_VALUE, timeout_reg=cnt=TIMEOUT_DEFAULT.
  - state=RUNNING if TIMEOUT_DEFAULT!=0, else DISARMED.
  - readdata=0, tripped=0, out_port=RESET_VALUE.
  - Reset asserted mid-countdown or while tripped returns all of the above at the next edge.

Optional Feature:
- Macro: MOTOR_PIO_STICKY_TRIP_EN.
- Defined: a trip is latched. Kicks (DATA/OUTSET/OUTCLR writes) reload cnt and update data_reg but do not leave TRIPPED. Only a TIMEOUT write (or reset) clears the trip. This forces software to re-arm explicitly after a fault.
- Undefined: any kick clears TRIPPED and returns to RUNNING, as described above.

Test Plan:
- Reset with TIMEOUT_DEFAULT=50000000 -> out_port=0, tripped=0, readdata=0. Read addr1 -> 0x02FAF080 one cycle later. Read addr2 -> 0x2.
- Write addr0=0xF5 (WIDTH=4) -> out_port=0x5 at the next edge. Write addr2=0x8 -> 0xD. Write addr3=0x1 -> 0xC. Read addr0 -> 0x0000000C.
- Write addr1=10, then no writes -> tripped rises exactly 10 cycles after that write edge. out_port=SAFE_VALUE. Read addr3 -> 0, addr2 -> 0x3.
- Write addr1=10, then a DATA write when cnt==1 -> no trip, and cnt reads 10 on the following cycle.
- While tripped, write addr0=0x3:
  - Without the macro: tripped=0, out_port=0x3.
  - With MOTOR_PIO_STICKY_TRIP_EN: tripped stays 1, out_port=SAFE_VALUE, readback addr0=0x3. A subsequent addr1=100 write clears the trip and out_port becomes 0x3.
- Write addr1=0 while tripped -> DISARMED, out_port=data_reg, cnt frozen over 1000 idle cycles. Assert reset mid-run -> all reset values restored at the next edge.
